// File: rtl/alu_cmd_sequencer_pkg.sv
// Opcode constants shared with the ALU control decoder, plus the
// sequencer FSM state encoding.
package alu_cmd_sequencer_pkg;

   localparam logic [2:0] OP_ADD     = 3'b000;
   localparam logic [2:0] OP_SUB     = 3'b001;
   localparam logic [2:0] OP_SRA     = 3'b010;
   localparam logic [2:0] OP_SRL     = 3'b011;
   localparam logic [2:0] OP_SLL     = 3'b100;
   localparam logic [2:0] OP_AND     = 3'b101;
   localparam logic [2:0] OP_OR      = 3'b110;
   localparam logic [2:0] OP_ILLEGAL = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_t;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Accepts ALU commands, iterates the external combinational ALU REP+1 times
// with the result fed back as operand A, and returns the final result.
module alu_cmd_sequencer
   import alu_cmd_sequencer_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = 4
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             CMD_VALID,
   output logic             CMD_READY,
   input  logic [2:0]       CMD_OP,
   input  logic [WIDTH-1:0] CMD_A,
   input  logic [WIDTH-1:0] CMD_B,
   input  logic [CNT_W-1:0] CMD_REP,
   output logic [2:0]       ALU_OP,
   output logic [WIDTH-1:0] ALU_A,
   output logic [WIDTH-1:0] ALU_B,
   input  logic [WIDTH-1:0] ALU_RESULT,
   output logic             RSP_VALID,
   input  logic             RSP_READY,
   output logic [WIDTH-1:0] RSP_DATA,
   output logic             RSP_ERR,
   output logic             BUSY
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state, state_nxt;
   logic [2:0]       op;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] b;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_err;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (CMD_VALID) state_nxt = (CMD_OP == OP_ILLEGAL) ? ST_RESP : ST_EXEC;
         ST_EXEC: if (cnt == '0) state_nxt = ST_RESP;
         ST_RESP: if (RSP_READY) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Command latch, feedback accumulator, repeat counter and response hold.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         op       <= '0;
         acc      <= '0;
         b        <= '0;
         cnt      <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (CMD_VALID) begin
                  if (CMD_OP == OP_ILLEGAL) begin
                     rsp_data <= '0;
                     rsp_err  <= 1'b1;
                  end else begin
                     op  <= CMD_OP;
                     acc <= CMD_A;
                     b   <= CMD_B;
                     cnt <= CMD_REP;
                  end
               end
            end
            ST_EXEC: begin
               acc <= ALU_RESULT;
               if (cnt == '0) begin
                  rsp_data <= ALU_RESULT;
                  rsp_err  <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            default: ;
         endcase
      end
   end

   // Outside EXEC the ALU is parked on ADD 0+0.
   always_comb begin
      CMD_READY = (state == ST_IDLE);
      BUSY      = (state != ST_IDLE);
      RSP_VALID = (state == ST_RESP);
      RSP_DATA  = rsp_data;
      RSP_ERR   = rsp_err;
      ALU_OP    = OP_ADD;
      ALU_A     = '0;
      ALU_B     = '0;
      if (state == ST_EXEC) begin
         ALU_OP = op;
         ALU_A  = acc;
         ALU_B  = b;
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU on the loop, vector table,
// response scoreboard, and hand-written reset / back-to-back sequences.
module tb_alu_cmd_sequencer;
   import alu_cmd_sequencer_pkg::*;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        CMD_VALID = 1'b0;
   logic        CMD_READY;
   logic [2:0]  CMD_OP = '0;
   logic [15:0] CMD_A = '0;
   logic [15:0] CMD_B = '0;
   logic [3:0]  CMD_REP = '0;
   logic [2:0]  ALU_OP;
   logic [15:0] ALU_A, ALU_B, ALU_RESULT;
   logic        RSP_VALID;
   logic        RSP_READY = 1'b1;
   logic [15:0] RSP_DATA;
   logic        RSP_ERR;
   logic        BUSY;

   int total = 0;
   int bad   = 0;
   int rsp_cnt = 0;
   logic [16:0] sb[$];

   typedef struct {
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  rep;
      logic [15:0] exp_d;
      logic        exp_e;
      int          stall;
   } vec_t;
   vec_t tbl[10];

   alu_cmd_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
      .CMD_A(CMD_A), .CMD_B(CMD_B), .CMD_REP(CMD_REP),
      .ALU_OP(ALU_OP), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_RESULT(ALU_RESULT),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
      .RSP_ERR(RSP_ERR), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_SRA:  return $unsigned($signed(a) >>> b[3:0]);
         OP_SRL:  return a >> b[3:0];
         OP_SLL:  return a << b[3:0];
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         default: return 16'h0000;
      endcase
   endfunction

   assign ALU_RESULT = alu_f(ALU_OP, ALU_A, ALU_B);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: pop on every response handshake.
   always @(negedge CLK) begin
      if (RESET_N && RSP_VALID && RSP_READY) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected: got data %h, want no response", RSP_DATA);
         end else begin
            logic [16:0] e;
            e = sb.pop_front();
            chk("rsp_data", 32'(RSP_DATA), 32'(e[15:0]));
            chk("rsp_err", 32'(RSP_ERR), 32'(e[16]));
         end
         rsp_cnt++;
      end
   end

   task automatic do_cmd(input vec_t v);
      int n;
      bit seen;
      logic [15:0] acc;
      RSP_READY = (v.stall == 0);
      @(negedge CLK);
      CMD_VALID = 1'b1; CMD_OP = v.op; CMD_A = v.a; CMD_B = v.b; CMD_REP = v.rep;
      n = 0;
      while (!CMD_READY && n < 50) begin @(negedge CLK); n++; end
      chk("cmd_accept_timeout", 32'(CMD_READY), 32'd1);
      sb.push_back({v.exp_e, v.exp_d});
      @(posedge CLK); #1 CMD_VALID = 1'b0;
      n = 0; seen = 0; acc = v.a;
      while (!seen && n < 40) begin
         @(negedge CLK); n++;
         if (RSP_VALID) seen = 1;
         else if (v.op != OP_ILLEGAL) begin
            chk("exec_alu_op", 32'(ALU_OP), 32'(v.op));
            chk("exec_alu_a", 32'(ALU_A), 32'(acc));
            chk("exec_alu_b", 32'(ALU_B), 32'(v.b));
            acc = alu_f(v.op, acc, v.b);
         end
      end
      chk("rsp_latency", 32'(n), (v.op == OP_ILLEGAL) ? 32'd1 : 32'(v.rep) + 32'd2);
      if (v.op == OP_ILLEGAL) chk("err_alu_op_quiet", 32'(ALU_OP), 32'(OP_ADD));
      if (v.stall > 0) begin
         for (int i = 0; i < v.stall; i++) begin
            chk("bp_valid", 32'(RSP_VALID), 32'd1);
            chk("bp_data", 32'(RSP_DATA), 32'(v.exp_d));
            chk("bp_cmd_ready", 32'(CMD_READY), 32'd0);
            @(negedge CLK);
         end
         @(posedge CLK); #1 RSP_READY = 1'b1;
         @(negedge CLK);
      end
      @(negedge CLK);
      chk("post_rsp_valid", 32'(RSP_VALID), 32'd0);
      chk("post_cmd_ready", 32'(CMD_READY), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish before 200us");
      $fatal(1);
   end

   initial begin
      int n;
      bit seen, viol;
      int base;
      tbl[0] = '{OP_ADD,     16'h0005, 16'h0003, 4'd2,  16'd14,   1'b0, 0};
      tbl[1] = '{OP_SUB,     16'h0000, 16'h0001, 4'd0,  16'hFFFF, 1'b0, 0};
      tbl[2] = '{OP_SLL,     16'h0001, 16'h0001, 4'd3,  16'd16,   1'b0, 0};
      tbl[3] = '{OP_OR,      16'h00F0, 16'h0F00, 4'd0,  16'h0FF0, 1'b0, 7};
      tbl[4] = '{OP_ILLEGAL, 16'h1234, 16'h5678, 4'd5,  16'h0000, 1'b1, 0};
      tbl[5] = '{OP_AND,     16'hFFFF, 16'h1234, 4'd0,  16'h1234, 1'b0, 0};
      tbl[6] = '{OP_SRA,     16'h8000, 16'h0001, 4'd0,  16'hC000, 1'b0, 0};
      tbl[7] = '{OP_SRL,     16'h8000, 16'h0004, 4'd1,  16'h0080, 1'b0, 0};
      tbl[8] = '{OP_SUB,     16'h0010, 16'h0003, 4'd15, 16'hFFE0, 1'b0, 0};
      tbl[9] = '{OP_ADD,     16'hFFFF, 16'h0001, 4'd0,  16'h0000, 1'b0, 2};

      repeat (2) @(negedge CLK);
      chk("rst_cmd_ready", 32'(CMD_READY), 32'd1);
      chk("rst_alu_op", 32'(ALU_OP), 32'd0);
      chk("rst_alu_a", 32'(ALU_A), 32'd0);
      chk("rst_alu_b", 32'(ALU_B), 32'd0);
      chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
      chk("rst_rsp_data", 32'(RSP_DATA), 32'd0);
      chk("rst_rsp_err", 32'(RSP_ERR), 32'd0);
      chk("rst_busy", 32'(BUSY), 32'd0);
      #1 RESET_N = 1'b1;

      for (int i = 0; i < 10; i++) do_cmd(tbl[i]);

      // Reset in the middle of a long SLL: nothing may come back.
      @(negedge CLK);
      RSP_READY = 1'b1;
      CMD_VALID = 1'b1; CMD_OP = OP_SLL; CMD_A = 16'h0001; CMD_B = 16'h0001; CMD_REP = 4'd15;
      @(posedge CLK); #1 CMD_VALID = 1'b0;
      repeat (5) @(negedge CLK);
      chk("mid_exec_busy", 32'(BUSY), 32'd1);
      chk("mid_exec_alu_a", 32'(ALU_A), 32'd16);
      #1 RESET_N = 1'b0;
      #1;
      chk("arst_cmd_ready", 32'(CMD_READY), 32'd1);
      chk("arst_busy", 32'(BUSY), 32'd0);
      chk("arst_rsp_valid", 32'(RSP_VALID), 32'd0);
      chk("arst_alu_op", 32'(ALU_OP), 32'd0);
      chk("arst_alu_a", 32'(ALU_A), 32'd0);
      chk("arst_alu_b", 32'(ALU_B), 32'd0);
      chk("arst_rsp_data", 32'(RSP_DATA), 32'd0);
      repeat (2) @(posedge CLK);
      #1 RESET_N = 1'b1;
      seen = 0;
      repeat (20) begin @(negedge CLK); if (RSP_VALID) seen = 1; end
      chk("arst_no_rsp", 32'(seen), 32'd0);
      do_cmd('{OP_SLL, 16'h0001, 16'h0001, 4'd3, 16'd16, 1'b0, 0});

      // Back-to-back with CMD_VALID held: second accept only after first handshake.
      base = rsp_cnt;
      viol = 0;
      @(negedge CLK);
      RSP_READY = 1'b1;
      CMD_VALID = 1'b1; CMD_OP = OP_AND; CMD_A = 16'hFFFF; CMD_B = 16'h1234; CMD_REP = 4'd0;
      sb.push_back({1'b0, 16'h1234});
      sb.push_back({1'b0, 16'hC000});
      @(posedge CLK); #1;
      CMD_OP = OP_SRA; CMD_A = 16'h8000; CMD_B = 16'h0001;
      n = 0; seen = 0;
      while (!seen && n < 30) begin
         @(negedge CLK); n++;
         if (CMD_READY) begin
            if (rsp_cnt < base + 1) viol = 1;
            seen = 1;
         end
      end
      chk("b2b_second_accept", 32'(seen), 32'd1);
      chk("b2b_no_early_accept", 32'(viol), 32'd0);
      @(posedge CLK); #1 CMD_VALID = 1'b0;
      n = 0;
      while (rsp_cnt < base + 2 && n < 30) begin @(negedge CLK); n++; end
      chk("b2b_rsp_count", 32'(rsp_cnt - base), 32'd2);

      repeat (3) @(negedge CLK);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
